fetch_stage: RTL and testbench

//  IF stage of the 5-stage RV32I pipeline: owns the PC register, drives the

---
 rtl/fetch_stage.sv | 130 +++++++++++++
 tb/tb_fetch_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// IF stage: PC register, combinational instruction-memory address, and the
// IF/ID pipeline register with stall/flush/redirect handling.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
    parameter int unsigned IMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        pc_src_e,
    input  logic [31:0] pc_target_e,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d,
    output logic        fetch_err_d,
    output logic        state_dbg
);

    // valid_d marks a real instruction in IF/ID. There is no ready signal:
    // decode backpressure arrives as stall_d, cancellation as flush_d.

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] pc_f;
    logic [31:0] pc_f_next;
    logic [31:0] pc_f_plus4;

    logic [31:0] instr_next;
    logic [31:0] pc_d_next;
    logic [31:0] pc_plus4_next;
    logic        valid_next;
    logic        fetch_err_next;

    logic        addr_aligned;
    logic        addr_in_range;
    logic        fetch_legal;

    assign imem_addr  = pc_f;
    assign pc_f_plus4 = pc_f + 32'd4;
    assign state_dbg  = state;

    assign addr_aligned  = (pc_f[1:0] == 2'b00);
    assign addr_in_range = ({2'b00, pc_f[31:2]} < 32'(IMEM_WORDS));
    assign fetch_legal   = addr_aligned && addr_in_range;

    always_comb begin
        state_next = state;
        if (state == BOOT) begin
            state_next = RUN;
        end
    end

    // Redirect beats stall_f: a taken branch must leave the stalled wrong path.
    always_comb begin
        pc_f_next = pc_f;
        if (state == RUN) begin
            if (pc_src_e) begin
                pc_f_next = pc_target_e;
            end else if (!stall_f) begin
                pc_f_next = pc_f_plus4;
            end
        end
    end

    always_comb begin
        instr_next     = instr_d;
        pc_d_next      = pc_d;
        pc_plus4_next  = pc_plus4_d;
        valid_next     = valid_d;
        fetch_err_next = fetch_err_d;
        if (state == BOOT || flush_d) begin
            instr_next     = NOP_INSTR;
            pc_d_next      = 32'd0;
            pc_plus4_next  = 32'd0;
            valid_next     = 1'b0;
            fetch_err_next = 1'b0;
        end else if (!stall_d) begin
            pc_d_next     = pc_f;
            pc_plus4_next = pc_f_plus4;
            if (fetch_legal) begin
                instr_next     = imem_rdata;
                valid_next     = 1'b1;
                fetch_err_next = 1'b0;
            end else begin
                instr_next     = NOP_INSTR;
                valid_next     = 1'b0;
                fetch_err_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
            pc_f  <= RESET_PC;
        end else begin
            state <= state_next;
            pc_f  <= pc_f_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_d     <= NOP_INSTR;
            pc_d        <= 32'd0;
            pc_plus4_d  <= 32'd0;
            valid_d     <= 1'b0;
            fetch_err_d <= 1'b0;
        end else begin
            instr_d     <= instr_next;
            pc_d        <= pc_d_next;
            pc_plus4_d  <= pc_plus4_next;
            valid_d     <= valid_next;
            fetch_err_d <= fetch_err_next;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by randomized hazard
// traffic, all compared against a behavioural model of the fetch rules.
module tb_fetch_stage;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          WORDS = 1024;

    logic        clk;
    logic        rst;
    logic        stall_f;
    logic        stall_d;
    logic        flush_d;
    logic        pc_src_e;
    logic [31:0] pc_target_e;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;
    logic        fetch_err_d;
    logic        state_dbg;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [WORDS];

    // Behavioural model: architectural PC plus the decode-visible slot.
    logic [31:0] m_pc;
    logic        m_boot;
    logic [31:0] m_instr;
    logic [31:0] m_pcd;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic        m_err;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
        .pc_src_e    (pc_src_e),
        .pc_target_e (pc_target_e),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc_plus4_d  (pc_plus4_d),
        .valid_d     (valid_d),
        .fetch_err_d (fetch_err_d),
        .state_dbg   (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Out-of-range reads return a poison word the DUT must never forward.
    assign imem_rdata = (imem_addr[31:2] < 30'(WORDS)) ? mem[imem_addr[11:2]] : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_boot  = 1'b1;
        m_instr = NOP;
        m_pcd   = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_bubble();
        m_instr = NOP;
        m_pcd   = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_step();
        logic ok;
        if (m_boot) begin
            model_bubble();
            m_boot = 1'b0;
        end else begin
            if (flush_d) begin
                model_bubble();
            end else if (!stall_d) begin
                ok      = (m_pc % 4 == 0) && ((m_pc / 4) < WORDS);
                m_pcd   = m_pc;
                m_pc4   = m_pc + 32'd4;
                m_instr = ok ? mem[m_pc / 4] : NOP;
                m_valid = ok;
                m_err   = !ok;
            end
            if (pc_src_e)      m_pc = pc_target_e;
            else if (!stall_f) m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".imem_addr"},   imem_addr,   m_pc);
        chk({tag, ".instr_d"},     instr_d,     m_instr);
        chk({tag, ".pc_d"},        pc_d,        m_pcd);
        chk({tag, ".pc_plus4_d"},  pc_plus4_d,  m_pc4);
        chk({tag, ".valid_d"},     32'(valid_d),     32'(m_valid));
        chk({tag, ".fetch_err_d"}, 32'(fetch_err_d), 32'(m_err));
        chk({tag, ".state"},       32'(state_dbg),   32'(!m_boot));
    endtask

    task automatic set_in(input logic sf, input logic sd, input logic fl,
                          input logic src, input logic [31:0] tgt);
        stall_f     = sf;
        stall_d     = sd;
        flush_d     = fl;
        pc_src_e    = src;
        pc_target_e = tgt;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(tag);
    endtask

    // Asynchronous reset raised between edges, checked before any clock.
    task automatic reset_pulse(input string tag);
        #2 rst = 1'b1;
        #1 model_reset();
        check_all({tag, ".async"});
        chk({tag, ".async_pc"}, imem_addr, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all({tag, ".held"});
    endtask

    initial begin
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        foreach (mem[i]) mem[i] = $urandom;
        mem[0] = 32'hA000_0001;
        mem[1] = 32'hB000_0002;
        mem[2] = 32'hC000_0003;
        mem[3] = 32'hD000_0004;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all("por");
        chk("por.instr", instr_d, NOP);
        rst = 1'b0;

        // Boot cycle holds PC at 0, then straight-line fetch A..D.
        step("boot");
        chk("boot.pc", imem_addr, 32'h0);
        chk("boot.valid", 32'(valid_d), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step("line");
            chk("line.instr", instr_d, mem[i]);
            chk("line.pc_d", pc_d, 32'(4 * i));
            chk("line.pc4", pc_plus4_d, 32'(4 * i + 4));
            chk("line.valid", 32'(valid_d), 32'h1);
        end

        // Mid-run reset, then load-use stall at pc_f=0x8.
        reset_pulse("rst_mid");
        step("boot2");
        step("run0");
        step("run1");
        chk("pre_stall.addr", imem_addr, 32'h8);
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            step("stall");
            chk("stall.addr", imem_addr, 32'h8);
            chk("stall.pc_d", pc_d, 32'h4);
            chk("stall.instr", instr_d, 32'hB000_0002);
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step("unstall0");
        chk("unstall0.pc_d", pc_d, 32'h8);
        step("unstall1");
        chk("unstall1.pc_d", pc_d, 32'hC);

        // Redirect with flush overriding stall_f.
        set_in(1'b1, 1'b0, 1'b1, 1'b1, 32'h40);
        step("redir");
        chk("redir.addr", imem_addr, 32'h40);
        chk("redir.bubble", instr_d, NOP);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step("redir_tgt");
        chk("redir_tgt.pc_d", pc_d, 32'h40);
        chk("redir_tgt.instr", instr_d, mem[16]);

        // Illegal fetch: past end of memory, and misaligned.
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 32'h1000);
        step("oob_redir");
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step("oob");
        chk("oob.err", 32'(fetch_err_d), 32'h1);
        chk("oob.instr", instr_d, NOP);
        chk("oob.addr", imem_addr, 32'h1004);
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 32'h42);
        step("mis_redir");
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step("mis");
        chk("mis.err", 32'(fetch_err_d), 32'h1);
        chk("mis.valid", 32'(valid_d), 32'h0);
        chk("mis.addr", imem_addr, 32'h46);

        // Wrap from the top of the address space.
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        step("wrap_redir");
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step("wrap");
        chk("wrap.err", 32'(fetch_err_d), 32'h1);
        chk("wrap.addr", imem_addr, 32'h0);
        step("wrap_next");
        chk("wrap_next.instr", instr_d, mem[0]);
        chk("wrap_next.valid", 32'(valid_d), 32'h1);

        // Randomized hazard traffic with occasional asynchronous reset.
        for (int n = 0; n < 2000; n++) begin
            logic [31:0] tgt;
            case ($urandom_range(0, 3))
                0:       tgt = 32'(4 * $urandom_range(0, WORDS - 1));
                1:       tgt = 32'(4 * $urandom_range(WORDS - 4, WORDS + 4));
                2:       tgt = $urandom;
                default: tgt = 32'(4 * $urandom_range(0, 63)) | 32'($urandom_range(0, 3));
            endcase
            set_in($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, tgt);
            if ($urandom_range(0, 249) == 0) begin
                reset_pulse("rnd_rst");
            end else begin
                step("rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
